// File: rtl/multi_cycle_ctrl_pkg.sv
// Shared definitions for the multi-cycle MIPS controller.
// Holds the state encodings, the supported opcode/funct values and the ALU
// operation codes, plus a helper that says whether an instruction is
// implemented. Every file that needs these imports this package; nothing
// redefines them locally.
package multi_cycle_ctrl_pkg;

  // Controller states (4-bit encoding, visible on the State debug port)
  localparam logic [3:0] S_FETCH  = 4'd0;
  localparam logic [3:0] S_DECODE = 4'd1;
  localparam logic [3:0] S_MEMADR = 4'd2;
  localparam logic [3:0] S_MEMRD  = 4'd3;
  localparam logic [3:0] S_MEMWB  = 4'd4;
  localparam logic [3:0] S_MEMWR  = 4'd5;
  localparam logic [3:0] S_EXEC   = 4'd6;
  localparam logic [3:0] S_RWB    = 4'd7;
  localparam logic [3:0] S_BRANCH = 4'd8;
  localparam logic [3:0] S_JUMP   = 4'd9;

  // Opcodes (instruction[31:26])
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;

  // R-type function codes (instruction[5:0])
  localparam logic [5:0] FUNCT_ADDU = 6'b100001;
  localparam logic [5:0] FUNCT_SUBU = 6'b100011;

  // ALU operation codes
  localparam logic [1:0] ALU_ADD_OP = 2'b00;
  localparam logic [1:0] ALU_SUB_OP = 2'b01;
  localparam logic [1:0] ALU_OR_OP  = 2'b10;

  // True when the opcode/funct pair is one the controller implements.
  function automatic logic is_legal(input logic [5:0] op, input logic [5:0] funct);
    logic ok;
    ok = 1'b0;
    case (op)
      OP_RTYPE: ok = (funct == FUNCT_ADDU) || (funct == FUNCT_SUBU);
      OP_ORI, OP_LW, OP_SW, OP_BEQ, OP_J: ok = 1'b1;
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/multi_cycle_ctrl.sv
// Multi-cycle MIPS controller sequencing one shared ALU and one shared memory.
// Supports addu, subu, ori, lw, sw, beq and j; any other instruction is
// flagged with a one-cycle Illegal pulse in DECODE and dropped.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   Op, Funct, Zero       instruction fields held in the IR, ALU zero flag
//   MemReady              memory access completes this cycle
//   PCWr .. ALUOp         datapath control strobes and mux selects
//   Illegal               one-cycle pulse when an unsupported op is decoded
//   InstrCnt              retired-instruction counter (wraps silently)
//   State                 current state, for debug
module multi_cycle_ctrl
  import multi_cycle_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic [5:0]  Op,
  input  logic [5:0]  Funct,
  input  logic        Zero,
  input  logic        MemReady,
  output logic        PCWr,
  output logic        IRWr,
  output logic        RegWr,
  output logic        MemRd,
  output logic        MemWr,
  output logic        IorD,
  output logic        RegDst,
  output logic        MemToReg,
  output logic        ALUSrcA,
  output logic [1:0]  ALUSrcB,
  output logic [1:0]  PCSource,
  output logic        ExtOp,
  output logic [1:0]  ALUOp,
  output logic        Illegal,
  output logic [31:0] InstrCnt,
  output logic [3:0]  State
);

  logic [3:0]  state;
  logic [3:0]  state_next;
  logic [31:0] instr_cnt;
  logic        retire;

  // An instruction retires on the edge that takes us back to FETCH from a
  // completing state; illegal ops leave DECODE without retiring.
  assign retire = (state == S_MEMWB) || (state == S_RWB) ||
                  (state == S_BRANCH) || (state == S_JUMP) ||
                  ((state == S_MEMWR) && MemReady);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_FETCH;
      instr_cnt <= 32'd0;
    end else begin
      state <= state_next;
      if (retire)
        instr_cnt <= instr_cnt + 32'd1;
    end
  end

  assign State    = state;
  assign InstrCnt = instr_cnt;

  // Next-state logic
  always_comb begin
    state_next = S_FETCH;
    case (state)
      S_FETCH:  state_next = MemReady ? S_DECODE : S_FETCH;
      S_DECODE: begin
        if (!is_legal(Op, Funct))
          state_next = S_FETCH;
        else begin
          case (Op)
            OP_LW, OP_SW:     state_next = S_MEMADR;
            OP_RTYPE, OP_ORI: state_next = S_EXEC;
            OP_BEQ:           state_next = S_BRANCH;
            OP_J:             state_next = S_JUMP;
            default:          state_next = S_FETCH;
          endcase
        end
      end
      S_MEMADR: state_next = (Op == OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD:  state_next = MemReady ? S_MEMWB : S_MEMRD;
      S_MEMWR:  state_next = MemReady ? S_FETCH : S_MEMWR;
      S_EXEC:   state_next = S_RWB;
      S_MEMWB, S_RWB, S_BRANCH, S_JUMP: state_next = S_FETCH;
      default:  state_next = S_FETCH;
    endcase
  end

  // Output decode. Everything defaults to 0 and stays 0 while rst_n is low,
  // so the datapath sees no strobes even though the state sits in FETCH.
  always_comb begin
    PCWr     = 1'b0;
    IRWr     = 1'b0;
    RegWr    = 1'b0;
    MemRd    = 1'b0;
    MemWr    = 1'b0;
    IorD     = 1'b0;
    RegDst   = 1'b0;
    MemToReg = 1'b0;
    ALUSrcA  = 1'b0;
    ALUSrcB  = 2'b00;
    PCSource = 2'b00;
    ExtOp    = 1'b0;
    ALUOp    = 2'b00;
    Illegal  = 1'b0;
    if (rst_n) begin
      case (state)
        S_FETCH: begin
          MemRd    = 1'b1;
          ALUSrcB  = 2'b01;
          ALUOp    = ALU_ADD_OP;
          PCSource = 2'b00;
          // PC+4 and IR load only when the instruction word has arrived
          IRWr     = MemReady;
          PCWr     = MemReady;
        end
        S_DECODE: begin
          // Precompute the branch target while the op is being decoded
          ALUSrcB = 2'b11;
          ALUOp   = ALU_ADD_OP;
          ExtOp   = 1'b1;
          Illegal = !is_legal(Op, Funct);
        end
        S_MEMADR: begin
          ALUSrcA = 1'b1;
          ALUSrcB = 2'b10;
          ExtOp   = 1'b1;
          ALUOp   = ALU_ADD_OP;
        end
        S_MEMRD: begin
          MemRd = 1'b1;
          IorD  = 1'b1;
        end
        S_MEMWR: begin
          MemWr = 1'b1;
          IorD  = 1'b1;
        end
        S_MEMWB: begin
          RegWr    = 1'b1;
          MemToReg = 1'b1;
        end
        S_EXEC, S_RWB: begin
          // RWB keeps the ALU set up as in EXEC so the result stays stable
          ALUSrcA = 1'b1;
          if (Op == OP_RTYPE) begin
            ALUSrcB = 2'b00;
            ALUOp   = (Funct == FUNCT_SUBU) ? ALU_SUB_OP : ALU_ADD_OP;
          end else begin
            ALUSrcB = 2'b10;
            ExtOp   = 1'b0;
            ALUOp   = ALU_OR_OP;
          end
          if (state == S_RWB) begin
            RegWr  = 1'b1;
            RegDst = (Op == OP_RTYPE);
          end
        end
        S_BRANCH: begin
          ALUSrcA  = 1'b1;
          ALUSrcB  = 2'b00;
          ALUOp    = ALU_SUB_OP;
          PCSource = 2'b01;
          PCWr     = Zero;
        end
        S_JUMP: begin
          PCWr     = 1'b1;
          PCSource = 2'b10;
        end
        default: ;
      endcase
    end
  end

endmodule
